// File: rtl/keypad_pkg.sv
// Shared constants and key-index mapping for the keypad input path.
// The key encoder uses the same mapping, so res bit order is fixed here.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  function automatic int key_index(input int col, input int row);
    return col * KP_ROWS + row;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Matrix lines and debounced key state between the scanner and its neighbours.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KP_ROWS-1:0] H;
  logic [KP_COLS-1:0] V;
  logic [KP_KEYS-1:0] res;
  logic               frame;

  modport master (input H, output V, res, frame);
  modport slave  (output H, input V, res, frame);

endinterface

// File: rtl/keypad_debounce_cell.sv
// Debounce state for a single key. A raw value that disagrees with the held
// state must persist for DEB_COUNT consecutive samples before it is adopted.
module keypad_debounce_cell #(
  parameter int DEB_COUNT = 4,
  parameter int CNT_W     = 3
) (
  input  logic Clock,
  input  logic Reset,
  input  logic sample_en,
  input  logic raw,
  output logic state
);

  logic [CNT_W-1:0] cnt;

  // Any agreeing sample throws away a partial run, so glitches never land.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sample_en) begin
      if (raw == state) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_COUNT - 1)) begin
        state <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: drives one column at a time, samples the synchronized
// rows at the end of each dwell and debounces every key independently.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_COUNT = 4,
  parameter int CNT_W     = 3
) (
  input logic              Clock,
  input logic              Reset,
  keypad_scanner_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int COL_W = $clog2(KP_COLS);

  logic [KP_ROWS-1:0] h_meta;
  logic [KP_ROWS-1:0] h_s;
  logic [DIV_W-1:0]   div;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   col_next;
  logic               sample;
  logic [KP_KEYS-1:0] state_vec;

  assign sample   = (div == DIV_W'(SCAN_DIV - 1));
  assign col_next = col + 1'b1;

  // Rows are idle-high, so the synchronizer resets to "nothing pressed".
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      h_meta <= '1;
      h_s    <= '1;
    end else begin
      h_meta <= kp.H;
      h_s    <= h_meta;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div      <= '0;
      col      <= '0;
      kp.V     <= 4'b1110;
      kp.frame <= 1'b0;
    end else begin
      kp.frame <= sample && (col == COL_W'(KP_COLS - 1));
      if (sample) begin
        div  <= '0;
        col  <= col_next;
        kp.V <= ~(4'b0001 << col_next);
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < KP_COLS; c++) begin : g_col
    for (genvar r = 0; r < KP_ROWS; r++) begin : g_row
      keypad_debounce_cell #(
        .DEB_COUNT(DEB_COUNT),
        .CNT_W    (CNT_W)
      ) u_cell (
        .Clock    (Clock),
        .Reset    (Reset),
        .sample_en(sample && (col == COL_W'(c))),
        .raw      (~h_s[r]),
        .state    (state_vec[key_index(c, r)])
      );
    end
  end

  assign kp.res = state_vec;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a behavioural key matrix driving the rows.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV  = 8;
  localparam int DEB_COUNT = 3;
  localparam int FRAME_LEN = 4 * SCAN_DIV;

  typedef struct {
    logic [15:0] keys;
    logic [15:0] exp_res;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic        use_rand = 1'b1;
  logic [3:0]  h_rand = 4'hF;
  logic [3:0]  h_model;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [21];

  always #5 Clock = ~Clock;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_COUNT(DEB_COUNT),
    .CNT_W    (3)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .kp   (kp.master)
  );

  // A held key pulls its row low only while its column is driven low.
  always_comb begin
    h_model = 4'hF;
    for (int c = 0; c < KP_COLS; c++)
      for (int r = 0; r < KP_ROWS; r++)
        if (keys[key_index(c, r)] && !kp.V[c]) h_model[r] = 1'b0;
  end

  assign kp.H = use_rand ? h_rand : h_model;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] k);
    keys = k;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic step_frame();
    repeat (FRAME_LEN) @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    tbl[0]  = '{16'h0020, 16'h0000};
    tbl[1]  = '{16'h0020, 16'h0000};
    tbl[2]  = '{16'h0020, 16'h0020};
    tbl[3]  = '{16'h0000, 16'h0020};
    tbl[4]  = '{16'h0000, 16'h0020};
    tbl[5]  = '{16'h0000, 16'h0000};
    tbl[6]  = '{16'h0020, 16'h0000};
    tbl[7]  = '{16'h0020, 16'h0000};
    tbl[8]  = '{16'h0000, 16'h0000};
    tbl[9]  = '{16'h0020, 16'h0000};
    tbl[10] = '{16'h0020, 16'h0000};
    tbl[11] = '{16'h0000, 16'h0000};
    tbl[12] = '{16'h0020, 16'h0000};
    tbl[13] = '{16'h0020, 16'h0000};
    tbl[14] = '{16'h0020, 16'h0020};
    tbl[15] = '{16'h0000, 16'h0020};
    tbl[16] = '{16'h0000, 16'h0020};
    tbl[17] = '{16'h0000, 16'h0000};
    tbl[18] = '{16'h8001, 16'h0000};
    tbl[19] = '{16'h8001, 16'h0000};
    tbl[20] = '{16'h8001, 16'h8001};

    // Reset held with random row activity.
    for (int i = 0; i < 5; i++) begin
      h_rand = 4'($urandom);
      @(negedge Clock);
      check_output("reset_V", {12'h0, kp.V}, 16'h000E);
      check_output("reset_res", kp.res, 16'h0000);
      check_output("reset_frame", {15'h0, kp.frame}, 16'h0000);
    end
    use_rand = 1'b0;
    Reset = 1'b1;

    // Column walk and frame pulse timing over two frames.
    for (int e = 0; e < 2 * FRAME_LEN; e++) begin
      logic [3:0] exp_v;
      int         c;
      @(posedge Clock);
      @(negedge Clock);
      c = ((e + 1) / SCAN_DIV) % KP_COLS;
      exp_v = ~(4'b0001 << c);
      check_output($sformatf("walk_V_e%0d", e), {12'h0, kp.V}, {12'h0, exp_v});
      check_output($sformatf("walk_frame_e%0d", e), {15'h0, kp.frame},
                   {15'h0, ((e % FRAME_LEN) == FRAME_LEN - 1)});
    end

    // Frame-by-frame debounce vectors from a fresh reset.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      apply_stimulus(tbl[i].keys);
      step_frame();
      check_output($sformatf("tbl_res_%0d", i), kp.res, tbl[i].exp_res);
      check_output($sformatf("tbl_frame_%0d", i), {15'h0, kp.frame}, 16'h0001);
    end

    // Keys 0 and 15 land at their own column samples in frame 2.
    do_reset();
    apply_stimulus(16'h8001);
    step_frame();
    step_frame();
    repeat (SCAN_DIV - 1) @(posedge Clock);
    @(negedge Clock);
    check_output("multi_before_col0", kp.res, 16'h0000);
    @(posedge Clock);
    @(negedge Clock);
    check_output("multi_at_col0", kp.res, 16'h0001);
    check_output("multi_col0_frame", {15'h0, kp.frame}, 16'h0000);
    repeat (FRAME_LEN - SCAN_DIV - 1) @(posedge Clock);
    @(negedge Clock);
    check_output("multi_before_col3", kp.res, 16'h0001);
    check_output("multi_before_col3_frame", {15'h0, kp.frame}, 16'h0000);
    @(posedge Clock);
    @(negedge Clock);
    check_output("multi_at_col3", kp.res, 16'h8001);
    check_output("multi_col3_frame", {15'h0, kp.frame}, 16'h0001);

    // Async reset in the middle of key 5's debounce run.
    do_reset();
    apply_stimulus(16'h0020);
    step_frame();
    step_frame();
    check_output("async_pre_res", kp.res, 16'h0000);
    repeat (SCAN_DIV + 4) @(posedge Clock);
    #2;
    check_output("async_pre_V", {12'h0, kp.V}, 16'h000D);
    Reset = 1'b0;
    #1;
    check_output("async_V", {12'h0, kp.V}, 16'h000E);
    check_output("async_res", kp.res, 16'h0000);
    check_output("async_frame", {15'h0, kp.frame}, 16'h0000);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    step_frame();
    check_output("async_post_f0", kp.res, 16'h0000);
    step_frame();
    check_output("async_post_f1", kp.res, 16'h0000);
    step_frame();
    check_output("async_post_f2", kp.res, 16'h0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
